// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 mid-bit majority, glitch-start rejection and framing check.
// Optional even-parity bit and parity_err port when UART_RX_PARITY_EN is defined.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int OS_DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t          state, state_nx;
  logic            rx_s1, rx_s2, rx_s3;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      sub_cnt;
  logic [2:0]      bit_cnt;
  logic [1:0]      samp;
  logic [7:0]      shift_reg;
  logic            tick, fall, resolve, bit_val;
  logic            done_set, ferr_set;
  logic            par_ok;

  // Sub-tick n is the n-th oversample tick into a bit: samples land at 7 and 8,
  // and the third sample is taken live at 9 where the bit is resolved.
  assign tick    = (tick_cnt == TW'(OS_DIV - 1));
  assign fall    = rx_s3 & ~rx_s2;
  assign resolve = tick && (sub_cnt == 4'd8);
  assign bit_val = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);
  assign rx_busy = state inside {START, DATA, PARITY, STOP};

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr_set;
  assign par_ok = ~((^shift_reg) ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // rx_done is a one-cycle valid with no ready: data_byte is held until the
  // next good byte, so the consumer may capture it on or after the pulse.
  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (resolve) state_nx = bit_val ? IDLE : DATA;
      DATA: begin
        if (resolve && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (resolve) state_nx = STOP;
`endif
      STOP: begin
        if (resolve) begin
          state_nx = WAIT_HIGH;
          if (!bit_val)    ferr_set = 1'b1;
          else if (par_ok) done_set = 1'b1;
`ifdef UART_RX_PARITY_EN
          else             perr_set = 1'b1;
`endif
        end
      end
      WAIT_HIGH: if (rx_s2) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      tick_cnt  <= '0;
      sub_cnt   <= '0;
      bit_cnt   <= '0;
      samp      <= '0;
      shift_reg <= '0;
      data_byte <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= rs232_rx;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      rx_done   <= done_set;
      frame_err <= ferr_set;
      if (done_set) data_byte <= shift_reg;
      if (!rx_busy) begin
        tick_cnt <= '0;
        sub_cnt  <= '0;
        bit_cnt  <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          sub_cnt <= sub_cnt + 1'b1;
          if (sub_cnt == 4'd6) samp[0] <= rx_s2;
          if (sub_cnt == 4'd7) samp[1] <= rx_s2;
        end
        if (state == DATA && resolve) begin
          shift_reg[bit_cnt] <= bit_val;
          bit_cnt            <= bit_cnt + 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_set;
      if (state == PARITY && resolve) par_bit <= bit_val;
    end
  end
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_byte_rx;

  localparam int BIT_CLKS = 432;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
  localparam int LATENCY = 4134 + BIT_CLKS;
`else
  localparam bit PAR_EN  = 1'b0;
  localparam int LATENCY = 4134;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       rs232_rx;
  logic [7:0] data_byte;
  logic       rx_done, frame_err, rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_byte_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rs232_rx  (rs232_rx),
    .data_byte (data_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] exp_last = 8'h00;
  int total = 0, bad = 0;
  int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int exp_done = 0, exp_ferr = 0, exp_perr = 0;
  int start_cyc = 0, last_done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // driver: line bits held BIT_CLKS each; returns early after abort_after clks if nonzero
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                            input int abort_after);
    logic frame [0:10];
    int   nb;
    int   n;
    logic good;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = b[i];
    if (PAR_EN) begin
      frame[9]  = par_bit;
      frame[10] = stop_bit;
      nb        = 11;
    end else begin
      frame[9]  = stop_bit;
      frame[10] = 1'b1;
      nb        = 10;
    end
    good = stop_bit && (!PAR_EN || (((^b) ^ par_bit) == 1'b0));
    if (abort_after == 0) begin
      if (good) begin
        exp_q.push_back(b);
        exp_last = b;
        exp_done++;
      end else if (!stop_bit) begin
        exp_ferr++;
      end else begin
        exp_perr++;
      end
    end
    n = 0;
    for (int i = 0; i < nb; i++) begin
      rs232_rx = frame[i];
      if (i == 0) start_cyc = cyc;
      for (int k = 0; k < BIT_CLKS; k++) begin
        @(negedge clk);
        n++;
        if (abort_after != 0 && n >= abort_after) return;
      end
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (rx_done || frame_err) begin
        check("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
        check("busy_low_at_pulse", {31'd0, rx_busy}, 32'd0);
      end
      if (rx_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("data_byte", {24'd0, data_byte}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err) begin
        ferr_cnt++;
        check("data_hold_ferr", {24'd0, data_byte}, {24'd0, exp_last});
      end
`ifdef UART_RX_PARITY_EN
      if (parity_err) begin
        perr_cnt++;
        check("perr_excl_done", {31'd0, rx_done}, 32'd0);
        check("data_hold_perr", {24'd0, data_byte}, {24'd0, exp_last});
      end
`endif
    end
  end

  initial begin
    int d0, f0, c0;
    logic [7:0] b;
    logic stop_b, par_b;
    int gap;

    rst      = 1'b0;
    rs232_rx = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_data_byte", {24'd0, data_byte}, 32'd0);
    check("rst_rx_done", {31'd0, rx_done}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // single frame with latency
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'hAA, 1'b1, ^8'hAA, 0);
    repeat (20) @(negedge clk);
    check("aa_done_count", done_cnt - d0, 1);
    check("aa_latency", last_done_cyc - start_cyc, LATENCY);
    check("aa_data", {24'd0, data_byte}, 32'hAA);
    check("aa_no_ferr", ferr_cnt - f0, 0);

    // back-to-back frames, zero idle
    d0 = done_cnt;
    send_frame(8'hAA, 1'b1, ^8'hAA, 0);
    send_frame(8'h55, 1'b1, ^8'h55, 0);
    repeat (20) @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 2);
    check("b2b_data", {24'd0, data_byte}, 32'h55);

    // 100-clk glitch from idle
    d0 = done_cnt;
    f0 = ferr_cnt;
    c0 = cyc;
    rs232_rx = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy_early", {31'd0, rx_busy}, 32'd1);
    repeat (50) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (140) @(negedge clk);
    check("glitch_busy_before_mid", {31'd0, rx_busy}, 32'd1);
    repeat (10) @(negedge clk);
    check("glitch_busy_after_mid", {31'd0, rx_busy}, 32'd0);
    check("glitch_elapsed", cyc - c0, 250);
    repeat (500) @(negedge clk);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // bad stop bit followed by a held-low break
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (500) @(negedge clk);
      check("break_busy_low", {31'd0, rx_busy}, 32'd0);
    end
    rs232_rx = 1'b1;
    repeat (500) @(negedge clk);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_no_done", done_cnt - d0, 0);
    check("ferr_data_kept", {24'd0, data_byte}, 32'h55);

    // reset in the middle of bit 4
    send_frame(8'hF0, 1'b1, ^8'hF0, 4 * BIT_CLKS + BIT_CLKS / 2);
    rst = 1'b0;
    #1;
    check("midrst_data", {24'd0, data_byte}, 32'd0);
    check("midrst_busy", {31'd0, rx_busy}, 32'd0);
    check("midrst_done", {31'd0, rx_done}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    exp_last = 8'h00;
    @(negedge clk);
    rs232_rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (500) @(negedge clk);
    d0 = done_cnt;
    send_frame(8'h0F, 1'b1, ^8'h0F, 0);
    repeat (20) @(negedge clk);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_data", {24'd0, data_byte}, 32'h0F);

`ifdef UART_RX_PARITY_EN
    d0 = done_cnt;
    f0 = perr_cnt;
    send_frame(8'h01, 1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    check("par_bad_perr", perr_cnt - f0, 1);
    check("par_bad_no_done", done_cnt - d0, 0);
    send_frame(8'h01, 1'b1, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("par_good_done", done_cnt - d0, 1);
    check("par_good_data", {24'd0, data_byte}, 32'h01);
`endif

    // random frames
    for (int i = 0; i < 8; i++) begin
      b      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = (^b) ^ ($urandom_range(0, 4) == 0);
      send_frame(b, stop_b, par_b, 0);
      gap = stop_b ? $urandom_range(0, 300) : $urandom_range(20, 300);
      rs232_rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    repeat (100) @(negedge clk);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_done_total", done_cnt, exp_done);
    check("final_ferr_total", ferr_cnt, exp_ferr);
    check("final_perr_total", perr_cnt, exp_perr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
